prog_ctr_stack: RTL and testbench

Parametrised next-generation program counter for the instruction-fetch stage. It adds the following over the single-mode counter:
- start-address load and run/halt control
- relative and absolute branches
- stall
- a hardware return-address stack for call/return, with error flagging

It drives the instruction-memory address every cycle and sits between the control decoder and instruction ROM.

---
 rtl/prog_ctr_stack.sv | 138 +++++++++++++
 tb/tb_prog_ctr_stack.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_ctr_stack.sv
// Instruction-fetch program counter with run/halt control, branches and a
// hardware return-address stack that flags overflow/underflow.
module prog_ctr_stack #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W       = $clog2(STACK_DEPTH) + 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [PC_W-1:0] StartAddr,
  input  logic            Stall,
  input  logic            Branch,
  input  logic            Jump,
  input  logic            Call,
  input  logic            Ret,
  input  logic            Halt,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Running,
  output logic            Done,
  output logic            StackErr,
  output logic [SP_W-1:0] StackCnt
);

  localparam int IDX_W = SP_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state_r, stateNext_s;
  logic [PC_W-1:0] pc_r, pcNext_s, pcInc_s;
  logic [SP_W-1:0] cnt_r, cntNext_s;
  logic            err_r, errNext_s;
  logic            running_r, done_r;
  logic            push_s;
  logic [PC_W-1:0] stack_r [STACK_DEPTH];
  logic [IDX_W-1:0] wrIdx_s, rdIdx_s;
  logic            stackEmpty_s, stackFull_s;

  // Occupancy low bits address the next free slot; top of stack sits one below.
  assign wrIdx_s      = cnt_r[IDX_W-1:0];
  assign rdIdx_s      = wrIdx_s - IDX_W'(1);
  assign stackEmpty_s = (cnt_r == SP_W'(0));
  assign stackFull_s  = (cnt_r == SP_W'(STACK_DEPTH));
  assign pcInc_s      = pc_r + PC_W'(1);

  // Next-state, next-PC and stack bookkeeping.
  always_comb begin
    stateNext_s = state_r;
    pcNext_s    = pc_r;
    cntNext_s   = cnt_r;
    errNext_s   = err_r;
    push_s      = 1'b0;
    case (state_r)
      IDLE, HALT: begin
        if (Start) begin
          pcNext_s    = StartAddr;
          cntNext_s   = SP_W'(0);
          errNext_s   = 1'b0;
          stateNext_s = RUN;
        end else begin
          stateNext_s = state_r;
        end
      end
      RUN: begin
        if (Stall) begin
          stateNext_s = RUN;
        end else if (Halt) begin
          stateNext_s = HALT;
        end else if (Ret) begin
          if (!stackEmpty_s) begin
            pcNext_s  = stack_r[rdIdx_s];
            cntNext_s = cnt_r - SP_W'(1);
          end else begin
            errNext_s = 1'b1;
            pcNext_s  = pcInc_s;
          end
        end else if (Call) begin
          if (!stackFull_s) begin
            push_s    = 1'b1;
            pcNext_s  = Target;
            cntNext_s = cnt_r + SP_W'(1);
          end else begin
            errNext_s = 1'b1;
            pcNext_s  = pcInc_s;
          end
        end else if (Jump) begin
          pcNext_s = Target;
        end else if (Branch) begin
          // Unsigned add at PC_W bits is the two's-complement relative branch with wrap.
          pcNext_s = pc_r + Target;
        end else begin
          pcNext_s = pcInc_s;
        end
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // Control state and registered status outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r   <= IDLE;
      pc_r      <= PC_W'(0);
      cnt_r     <= SP_W'(0);
      err_r     <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      pc_r      <= pcNext_s;
      cnt_r     <= cntNext_s;
      err_r     <= errNext_s;
      running_r <= (stateNext_s == RUN);
      done_r    <= (stateNext_s == HALT);
    end
  end

  // Return-address storage; contents are meaningless beyond the occupancy count.
  always_ff @(posedge Clk) begin
    if (push_s) begin
      stack_r[wrIdx_s] <= pcInc_s;
    end
  end

  assign ProgCtr  = pc_r;
  assign Running  = running_r;
  assign Done     = done_r;
  assign StackErr = err_r;
  assign StackCnt = cnt_r;

endmodule

// File: tb/tb_prog_ctr_stack.sv
// Self-checking bench for prog_ctr_stack: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_prog_ctr_stack;

  localparam int PC_W  = 10;
  localparam int DEPTH = 4;
  localparam int SP_W  = 3;
  localparam int MODN  = 1 << PC_W;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            Start, Stall, Branch, Jump, Call, Ret, Halt;
  logic [PC_W-1:0] StartAddr, Target;
  logic [PC_W-1:0] ProgCtr;
  logic            Running, Done, StackErr;
  logic [SP_W-1:0] StackCnt;

  int total = 0;
  int bad   = 0;

  // Reference model: 0=idle 1=run 2=halt, PC as integer, stack as queue.
  int mState;
  int mPc;
  int mStack[$];
  bit mErr;

  prog_ctr_stack #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .Branch(Branch), .Jump(Jump), .Call(Call), .Ret(Ret),
    .Halt(Halt), .Target(Target), .ProgCtr(ProgCtr), .Running(Running),
    .Done(Done), .StackErr(StackErr), .StackCnt(StackCnt)
  );

  always #5 Clk = ~Clk;

  task automatic modelReset();
    mState = 0;
    mPc    = 0;
    mStack.delete();
    mErr   = 1'b0;
  endtask

  task automatic modelStep();
    int off;
    if (mState == 1) begin
      if (Stall) begin
      end else if (Halt) begin
        mState = 2;
      end else if (Ret) begin
        if (mStack.size() > 0) mPc = mStack.pop_back();
        else begin mErr = 1'b1; mPc = (mPc + 1) % MODN; end
      end else if (Call) begin
        if (mStack.size() < DEPTH) begin
          mStack.push_back((mPc + 1) % MODN);
          mPc = int'(Target);
        end else begin
          mErr = 1'b1; mPc = (mPc + 1) % MODN;
        end
      end else if (Jump) begin
        mPc = int'(Target);
      end else if (Branch) begin
        off = (int'(Target) >= MODN / 2) ? int'(Target) - MODN : int'(Target);
        mPc = ((mPc + off) % MODN + MODN) % MODN;
      end else begin
        mPc = (mPc + 1) % MODN;
      end
    end else if (Start) begin
      mPc    = int'(StartAddr);
      mStack.delete();
      mErr   = 1'b0;
      mState = 1;
    end
  endtask

  task automatic clearCtl();
    Start = 1'b0; Stall = 1'b0; Branch = 1'b0; Jump = 1'b0;
    Call = 1'b0; Ret = 1'b0; Halt = 1'b0;
    StartAddr = '0; Target = '0;
  endtask

  task automatic tick();
    modelStep();
    @(posedge Clk);
    #1;
    clearCtl();
  endtask

  task automatic test_reset();
    clearCtl();
    Reset = 1'b0;
    modelReset();
    #12 Reset = 1'b1;
    repeat (3) tick();
    total++;
    if (ProgCtr !== 10'd0 || Running !== 1'b0 || Done !== 1'b0 || StackCnt !== 3'd0 || StackErr !== 1'b0) begin
      bad++;
      $display("FAIL reset: pc=%0d run=%b done=%b cnt=%0d err=%b want pc=0 run=0 done=0 cnt=0 err=0",
               ProgCtr, Running, Done, StackCnt, StackErr);
    end
  endtask

  task automatic test_increment_branch();
    Start = 1'b1; StartAddr = 10'd100; tick();
    total++;
    if (ProgCtr !== 10'd100 || Running !== 1'b1) begin
      bad++; $display("FAIL start: pc=%0d run=%b want pc=100 run=1", ProgCtr, Running);
    end
    tick(); tick();
    total++;
    if (ProgCtr !== 10'd102) begin bad++; $display("FAIL incr: got %0d want 102", ProgCtr); end
    Branch = 1'b1; Target = 10'd10; tick();
    total++;
    if (ProgCtr !== 10'd112) begin bad++; $display("FAIL branch_fwd: got %0d want 112", ProgCtr); end
    Branch = 1'b1; Target = 10'h3FB; tick();
    total++;
    if (ProgCtr !== 10'd107) begin bad++; $display("FAIL branch_back: got %0d want 107", ProgCtr); end
    Jump = 1'b1; Target = 10'd1020; tick();
    Branch = 1'b1; Target = 10'd10; tick();
    total++;
    if (ProgCtr !== 10'd6) begin bad++; $display("FAIL branch_wrap: got %0d want 6", ProgCtr); end
    Jump = 1'b1; Target = 10'd1023; tick();
    tick();
    total++;
    if (ProgCtr !== 10'd0) begin bad++; $display("FAIL incr_wrap: got %0d want 0", ProgCtr); end
  endtask

  task automatic test_call_ret();
    Jump = 1'b1; Target = 10'd50; tick();
    Call = 1'b1; Target = 10'd200; tick();
    total++;
    if (ProgCtr !== 10'd200 || StackCnt !== 3'd1) begin
      bad++; $display("FAIL call1: pc=%0d cnt=%0d want pc=200 cnt=1", ProgCtr, StackCnt);
    end
    Call = 1'b1; Target = 10'd300; tick();
    total++;
    if (ProgCtr !== 10'd300 || StackCnt !== 3'd2) begin
      bad++; $display("FAIL call2: pc=%0d cnt=%0d want pc=300 cnt=2", ProgCtr, StackCnt);
    end
    Ret = 1'b1; tick();
    total++;
    if (ProgCtr !== 10'd201) begin bad++; $display("FAIL ret1: got %0d want 201", ProgCtr); end
    Ret = 1'b1; tick();
    total++;
    if (ProgCtr !== 10'd51 || StackCnt !== 3'd0 || StackErr !== 1'b0) begin
      bad++; $display("FAIL ret2: pc=%0d cnt=%0d err=%b want pc=51 cnt=0 err=0", ProgCtr, StackCnt, StackErr);
    end
  endtask

  task automatic test_overflow_underflow();
    Jump = 1'b1; Target = 10'd10; tick();
    for (int i = 0; i < 4; i++) begin Call = 1'b1; Target = 10'd20; tick(); end
    total++;
    if (StackCnt !== 3'd4 || StackErr !== 1'b0) begin
      bad++; $display("FAIL fill: cnt=%0d err=%b want cnt=4 err=0", StackCnt, StackErr);
    end
    Call = 1'b1; Target = 10'd20; tick();
    total++;
    if (ProgCtr !== 10'd21 || StackErr !== 1'b1 || StackCnt !== 3'd4) begin
      bad++; $display("FAIL overflow: pc=%0d err=%b cnt=%0d want pc=21 err=1 cnt=4", ProgCtr, StackErr, StackCnt);
    end
    for (int i = 0; i < 4; i++) begin Ret = 1'b1; tick(); end
    total++;
    if (ProgCtr !== 10'd11 || StackCnt !== 3'd0) begin
      bad++; $display("FAIL drain: pc=%0d cnt=%0d want pc=11 cnt=0", ProgCtr, StackCnt);
    end
    Ret = 1'b1; tick();
    total++;
    if (ProgCtr !== 10'd12 || StackErr !== 1'b1 || StackCnt !== 3'd0) begin
      bad++; $display("FAIL underflow: pc=%0d err=%b cnt=%0d want pc=12 err=1 cnt=0", ProgCtr, StackErr, StackCnt);
    end
  endtask

  task automatic test_priority();
    Jump = 1'b1; Target = 10'd5; tick();
    Call = 1'b1; Jump = 1'b1; Branch = 1'b1; Target = 10'd40; tick();
    total++;
    if (ProgCtr !== 10'd40 || StackCnt !== 3'd1) begin
      bad++; $display("FAIL call_wins: pc=%0d cnt=%0d want pc=40 cnt=1", ProgCtr, StackCnt);
    end
    Stall = 1'b1; Ret = 1'b1; Halt = 1'b1; tick();
    total++;
    if (ProgCtr !== 10'd40 || StackCnt !== 3'd1 || Running !== 1'b1) begin
      bad++; $display("FAIL stall: pc=%0d cnt=%0d run=%b want pc=40 cnt=1 run=1", ProgCtr, StackCnt, Running);
    end
    Halt = 1'b1; Ret = 1'b1; tick();
    total++;
    if (Done !== 1'b1 || Running !== 1'b0 || ProgCtr !== 10'd40 || StackCnt !== 3'd1) begin
      bad++; $display("FAIL halt: done=%b run=%b pc=%0d cnt=%0d want done=1 run=0 pc=40 cnt=1",
                      Done, Running, ProgCtr, StackCnt);
    end
    Jump = 1'b1; Call = 1'b1; Target = 10'd99; tick();
    total++;
    if (ProgCtr !== 10'd40 || Done !== 1'b1) begin
      bad++; $display("FAIL halt_hold: pc=%0d done=%b want pc=40 done=1", ProgCtr, Done);
    end
  endtask

  task automatic test_halt_restart();
    Start = 1'b1; StartAddr = 10'd7; tick();
    total++;
    if (ProgCtr !== 10'd7 || Running !== 1'b1 || Done !== 1'b0 || StackErr !== 1'b0 || StackCnt !== 3'd0) begin
      bad++; $display("FAIL restart: pc=%0d run=%b done=%b err=%b cnt=%0d want pc=7 run=1 done=0 err=0 cnt=0",
                      ProgCtr, Running, Done, StackErr, StackCnt);
    end
    Start = 1'b1; StartAddr = 10'd500; tick();
    total++;
    if (ProgCtr !== 10'd8) begin bad++; $display("FAIL start_in_run: got %0d want 8", ProgCtr); end
  endtask

  task automatic test_async_reset();
    Call = 1'b1; Target = 10'd300; tick();
    #2 Reset = 1'b0;
    #1;
    modelReset();
    total++;
    if (ProgCtr !== 10'd0 || StackCnt !== 3'd0 || Running !== 1'b0 || StackErr !== 1'b0) begin
      bad++; $display("FAIL async_reset: pc=%0d cnt=%0d run=%b err=%b want all 0", ProgCtr, StackCnt, Running, StackErr);
    end
    #1 Reset = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_random();
    int errs = 0;
    Start = 1'b1; StartAddr = 10'($urandom); tick();
    for (int cyc = 0; cyc < 600; cyc++) begin
      Start     = ($urandom_range(0, 7) == 0);
      StartAddr = 10'($urandom);
      Stall     = ($urandom_range(0, 7) == 0);
      Halt      = ($urandom_range(0, 31) == 0);
      Ret       = ($urandom_range(0, 3) == 0);
      Call      = ($urandom_range(0, 3) == 0);
      Jump      = ($urandom_range(0, 7) == 0);
      Branch    = ($urandom_range(0, 3) == 0);
      Target    = 10'($urandom);
      tick();
      total++;
      if (ProgCtr !== 10'(mPc) || StackCnt !== 3'(mStack.size()) || StackErr !== mErr ||
          Running !== (mState == 1) || Done !== (mState == 2)) begin
        bad++;
        if (errs < 10) begin
          $display("FAIL rand cyc=%0d: pc=%0d cnt=%0d err=%b run=%b done=%b want pc=%0d cnt=%0d err=%b run=%b done=%b",
                   cyc, ProgCtr, StackCnt, StackErr, Running, Done,
                   mPc, mStack.size(), mErr, (mState == 1), (mState == 2));
        end
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_increment_branch();
    test_call_ret();
    test_overflow_underflow();
    test_priority();
    test_halt_restart();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
